// File: rtl/enc_link_pkg.sv
// Shared constants and types for the encrypted-frame link receiver.
package enc_link_pkg;

    localparam int FRAME_W = 78;
    localparam int CHUNK_W = 6;
    localparam int BEATS   = FRAME_W / CHUNK_W;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    typedef logic [$clog2(BEATS)-1:0] cnt_t;

endpackage

// File: rtl/enc_frame_rx_if.sv
// Link-side beat stream plus frame-side valid/ready output of the receiver.
interface enc_frame_rx_if;
    import enc_link_pkg::*;

    logic               rx_valid;
    logic               rx_sof;
    logic [CHUNK_W-1:0] rx_data;
    logic               rx_parity;
    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_err;
    logic [7:0]         overflow_cnt;

    modport master (
        output rx_valid, rx_sof, rx_data, rx_parity, frame_ready,
        input  frame_valid, frame_data, frame_err, overflow_cnt
    );

    modport slave (
        input  rx_valid, rx_sof, rx_data, rx_parity, frame_ready,
        output frame_valid, frame_data, frame_err, overflow_cnt
    );

endinterface

// File: rtl/frame_fifo.sv
// Small synchronous frame store; push while full is accepted only alongside a pop.
module frame_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 78
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        // Drive zeros when empty so the head reads as a clean reset value.
        head    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/enc_frame_rx.sv
// Reassembles parity-protected 6-bit link beats into 78-bit frames and buffers
// complete good frames for the decryption path.
module enc_frame_rx
    import enc_link_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          Clk,
    input  logic          Rst,
    enc_frame_rx_if.slave bus
);

    localparam logic [0:0] S_IDLE    = IDLE;
    localparam logic [0:0] S_COLLECT = COLLECT;
    localparam cnt_t       LAST_CNT  = cnt_t'(BEATS - 1);

    logic [0:0]         state;
    cnt_t               cnt;
    logic               perr;
    logic               err_p1;
    logic [7:0]         ovf_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] shifted;
    logic               par_bad;
    logic               frame_bad;
    logic               last_beat;
    logic               take_beat;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic               empty;

    always_comb begin
        par_bad   = ^{bus.rx_data, bus.rx_parity};
        shifted   = {shreg[FRAME_W-CHUNK_W-1:0], bus.rx_data};
        take_beat = bus.rx_valid && (bus.rx_sof || state == S_COLLECT);
        last_beat = (state == S_COLLECT) && bus.rx_valid && !bus.rx_sof && (cnt == LAST_CNT);
        frame_bad = perr || par_bad;
        pop       = !empty && bus.frame_ready;
        push      = last_beat && !frame_bad && (!full || pop);
        drop      = last_beat && !frame_bad && full && !pop;
    end

    // Stage p0: beat acceptance, frame assembly and error/overflow bookkeeping
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            perr    <= 1'b0;
            err_p1  <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            err_p1 <= 1'b0;
            if (bus.rx_valid) begin
                if (bus.rx_sof) begin
                    // A new SOF inside a frame aborts the partial one.
                    if (state == S_COLLECT) err_p1 <= 1'b1;
                    state <= S_COLLECT;
                    cnt   <= cnt_t'(1);
                    perr  <= par_bad;
                end else if (state == S_COLLECT) begin
                    if (cnt == LAST_CNT) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        perr  <= 1'b0;
                        if (frame_bad) err_p1 <= 1'b1;
                    end else begin
                        cnt  <= cnt + cnt_t'(1);
                        perr <= frame_bad;
                    end
                end
            end
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (take_beat) shreg <= shifted;
    end

    frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (push),
        .pop   (pop),
        .din   (shifted),
        .full  (full),
        .empty (empty),
        .head  (bus.frame_data)
    );

    assign bus.frame_valid  = !empty;
    assign bus.frame_err    = err_p1;
    assign bus.overflow_cnt = ovf_cnt;

endmodule

// File: tb/tb_enc_frame_rx.sv
// Directed bench for enc_frame_rx with a scoreboard of expected delivered frames.
module tb_enc_frame_rx;

    logic Clk;
    logic Rst;

    enc_frame_rx_if bus();

    enc_frame_rx #(.DEPTH(2)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;
    int err_seen = 0;
    int delivered = 0;
    logic [77:0] sb[$];

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops happen at the next rising edge; compare them half a cycle earlier.
    always @(negedge Clk) begin
        if (!Rst && bus.frame_err) err_seen++;
        if (!Rst && bus.frame_valid && bus.frame_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame", {2'b0, bus.frame_data}, 80'h0);
            end else begin
                chk("frame_data", {2'b0, bus.frame_data}, {2'b0, sb.pop_front()});
                delivered++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic beat(input logic [5:0] d, input logic sof, input logic bad);
        bus.rx_valid  = 1'b1;
        bus.rx_sof    = sof;
        bus.rx_data   = d;
        bus.rx_parity = (^d) ^ bad;
        @(posedge Clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [77:0] f, input int gap, input int bad_beat,
                              input int ready_at, input bit deliver);
        for (int i = 0; i < 13; i++) begin
            if (i == ready_at) bus.frame_ready = 1'b1;
            beat(f[77-6*i -: 6], i == 0, i == bad_beat);
            if (i < 12 && gap > 0) idle(gap);
        end
        if (deliver) sb.push_back(f);
    endtask

    localparam logic [77:0] F1 = 78'h2ABCDEF0123456789AB;
    localparam logic [77:0] FA = 78'h1111111111111111111;
    localparam logic [77:0] FB = 78'h2222222222222222222;
    localparam logic [77:0] FC = 78'h3333333333333333333;
    localparam logic [77:0] FX = 78'h0F0F0F0F0F0F0F0F0F0;

    initial begin
        int e0;
        logic [77:0] part;
        Rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_sof = 1'b0;
        bus.rx_data = '0;
        bus.rx_parity = 1'b0;
        bus.frame_ready = 1'b0;
        idle(3);
        chk("rst_valid", {79'b0, bus.frame_valid}, 80'h0);
        chk("rst_data", {2'b0, bus.frame_data}, 80'h0);
        chk("rst_err", {79'b0, bus.frame_err}, 80'h0);
        chk("rst_ovf", {72'b0, bus.overflow_cnt}, 80'h0);
        Rst = 1'b0;
        idle(1);

        // 1: contiguous good frame, one-cycle latency
        bus.frame_ready = 1'b1;
        send_frame(F1, 0, -1, -1, 1'b1);
        chk("t1_valid", {79'b0, bus.frame_valid}, 80'h1);
        chk("t1_data", {2'b0, bus.frame_data}, {2'b0, F1});
        idle(3);
        chk("t1_no_err", 80'(err_seen), 80'h0);

        // 2: stray beats then gapped frame
        beat(6'h15, 1'b0, 1'b0);
        beat(6'h2A, 1'b0, 1'b1);
        idle(2);
        send_frame(F1, 3, -1, -1, 1'b1);
        idle(3);
        chk("t2_no_err", 80'(err_seen), 80'h0);

        // 3: parity error on beat 5, then good frame
        send_frame(FX, 0, 5, -1, 1'b0);
        chk("t3_err_pulse", {79'b0, bus.frame_err}, 80'h1);
        chk("t3_no_valid", {79'b0, bus.frame_valid}, 80'h0);
        idle(1);
        chk("t3_err_low", {79'b0, bus.frame_err}, 80'h0);
        send_frame(FA, 0, -1, -1, 1'b1);
        idle(3);
        chk("t3_err_count", 80'(err_seen), 80'h1);

        // 4: SOF at beat 7 aborts, new frame delivered
        for (int i = 0; i < 7; i++) beat(FX[77-6*i -: 6], i == 0, 1'b0);
        e0 = err_seen;
        send_frame(FB, 0, -1, -1, 1'b1);
        idle(3);
        chk("t4_abort_err", 80'(err_seen - e0), 80'h1);

        // 5: overflow with buffer held
        bus.frame_ready = 1'b0;
        send_frame(FA, 0, -1, -1, 1'b1);
        send_frame(FB, 0, -1, -1, 1'b1);
        send_frame(FC, 0, -1, -1, 1'b0);
        chk("t5_ovf1", {72'b0, bus.overflow_cnt}, 80'h1);
        chk("t5_head", {2'b0, bus.frame_data}, {2'b0, FA});
        bus.frame_ready = 1'b1;
        idle(4);
        chk("t5_drained", 80'(sb.size()), 80'h0);
        chk("t5_empty", {79'b0, bus.frame_valid}, 80'h0);

        // 6a: pop coincides with last beat into a full buffer
        bus.frame_ready = 1'b0;
        send_frame(FB, 0, -1, -1, 1'b1);
        send_frame(FC, 0, -1, -1, 1'b1);
        send_frame(F1, 0, -1, 12, 1'b1);
        chk("t6_ovf_same", {72'b0, bus.overflow_cnt}, 80'h1);
        idle(4);
        chk("t6_drained", 80'(sb.size()), 80'h0);

        // 5b: saturate the overflow counter
        bus.frame_ready = 1'b0;
        send_frame(FA, 0, -1, -1, 1'b1);
        send_frame(FC, 0, -1, -1, 1'b1);
        for (int k = 0; k < 253; k++) send_frame(FX ^ 78'(k), 0, -1, -1, 1'b0);
        chk("t5_ovf254", {72'b0, bus.overflow_cnt}, 80'd254);
        for (int k = 0; k < 4; k++) send_frame(FB, 0, -1, -1, 1'b0);
        chk("t5_ovf_sat", {72'b0, bus.overflow_cnt}, 80'd255);
        chk("t5_head2", {2'b0, bus.frame_data}, {2'b0, FA});
        bus.frame_ready = 1'b1;
        idle(4);
        chk("t5b_drained", 80'(sb.size()), 80'h0);

        // 6b: reset mid-frame with a full buffer
        bus.frame_ready = 1'b0;
        send_frame(FA, 0, -1, -1, 1'b0);
        send_frame(FB, 0, -1, -1, 1'b0);
        for (int i = 0; i < 6; i++) beat(FC[77-6*i -: 6], i == 0, 1'b0);
        Rst = 1'b1;
        beat(FC[41:36], 1'b0, 1'b0);
        chk("t6_rst_valid", {79'b0, bus.frame_valid}, 80'h0);
        chk("t6_rst_data", {2'b0, bus.frame_data}, 80'h0);
        chk("t6_rst_err", {79'b0, bus.frame_err}, 80'h0);
        chk("t6_rst_ovf", {72'b0, bus.overflow_cnt}, 80'h0);
        Rst = 1'b0;
        for (int i = 7; i < 13; i++) beat(FC[77-6*i -: 6], 1'b0, 1'b0);
        idle(2);
        chk("t6_partial_gone", {79'b0, bus.frame_valid}, 80'h0);
        bus.frame_ready = 1'b1;
        part = F1 ^ FX;
        send_frame(part, 0, -1, -1, 1'b1);
        idle(3);

        chk("final_sb_empty", 80'(sb.size()), 80'h0);
        chk("final_delivered", 80'(delivered), 80'd12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
